// File: rtl/ac_pkg.sv
// Shared strap codes, bundle layout and filter FSM states for the system-check path.
package ac_pkg;

  localparam logic [1:0] PROC_ID_SPR    = 2'b00;
  localparam logic [1:0] PROC_ID_GNR    = 2'b10;
  localparam logic [2:0] PKG_ID_NON_MCP = 3'b000;
  localparam logic [2:0] PKG_ID_HBM     = 3'b010;

  // Bundle layout, MSB first: {SKT_OCC[1:0], PROC0[1:0], PROC1[1:0], PKG0[2:0], PKG1[2:0]}
  localparam int unsigned STRAP_W   = 12;
  localparam int unsigned SKT_W     = 2;
  localparam int unsigned ID_W      = 10;
  localparam int unsigned SKT_LSB   = 10;
  localparam int unsigned PROC0_LSB = 8;
  localparam int unsigned PROC1_LSB = 6;
  localparam int unsigned PKG0_LSB  = 3;
  localparam int unsigned PKG1_LSB  = 0;

  localparam logic [SKT_W-1:0] SKT_ABSENT = 2'b11;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_QUALIFY  = 2'd1,
    ST_LOCKED   = 2'd2
  } strapState_e;

  function automatic logic [ID_W-1:0] packIds(input logic [1:0] proc0, input logic [1:0] proc1,
                                              input logic [2:0] pkg0, input logic [2:0] pkg1);
    return {proc0, proc1, pkg0, pkg1};
  endfunction

endpackage

// File: rtl/ac_cpu_strap_filter_if.sv
// Raw CPU strap pins in, qualified strap values and status out.
interface ac_cpu_strap_filter_if;

  logic [1:0] ivCPU_SKT_OCC_RAW;
  logic [1:0] ivPROC_ID_CPU0_RAW;
  logic [1:0] ivPROC_ID_CPU1_RAW;
  logic [2:0] ivPKG_ID_CPU0_RAW;
  logic [2:0] ivPKG_ID_CPU1_RAW;

  logic [1:0] ovCPU_SKT_OCC;
  logic [1:0] ovPROC_ID_CPU0;
  logic [1:0] ovPROC_ID_CPU1;
  logic [2:0] ovPKG_ID_CPU0;
  logic [2:0] ovPKG_ID_CPU1;
  logic       oSTRAPS_VALID;
  logic       oSKT_CHANGE;
  logic       oID_DRIFT;

  modport master (
    output ivCPU_SKT_OCC_RAW, ivPROC_ID_CPU0_RAW, ivPROC_ID_CPU1_RAW,
           ivPKG_ID_CPU0_RAW, ivPKG_ID_CPU1_RAW,
    input  ovCPU_SKT_OCC, ovPROC_ID_CPU0, ovPROC_ID_CPU1, ovPKG_ID_CPU0, ovPKG_ID_CPU1,
           oSTRAPS_VALID, oSKT_CHANGE, oID_DRIFT
  );

  modport slave (
    input  ivCPU_SKT_OCC_RAW, ivPROC_ID_CPU0_RAW, ivPROC_ID_CPU1_RAW,
           ivPKG_ID_CPU0_RAW, ivPKG_ID_CPU1_RAW,
    output ovCPU_SKT_OCC, ovPROC_ID_CPU0, ovPROC_ID_CPU1, ovPKG_ID_CPU0, ovPKG_ID_CPU1,
           oSTRAPS_VALID, oSKT_CHANGE, oID_DRIFT
  );

endinterface

// File: rtl/ac_strap_debounce.sv
// Stability counter: counts cycles a sample has held steady while differing from a target.
module ac_strap_debounce #(
  parameter int unsigned WIDTH      = 12,
  parameter int unsigned DEB_CYCLES = 1000,
  parameter int unsigned CNT_W      = 10
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iClear,
  input  logic [WIDTH-1:0] ivTarget,
  input  logic [WIDTH-1:0] ivSample,
  output logic             oHeld,
  output logic             oAccept
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(DEB_CYCLES - 2);

  logic [WIDTH-1:0] prevQ;
  logic [CNT_W-1:0] cntQ;
  logic [CNT_W-1:0] cntD;
  logic             advance;

  assign advance = !iClear && (ivSample == prevQ) && (ivSample != ivTarget);

  always_comb begin
    cntD = '0;
    if (advance) begin
      cntD = (cntQ == CNT_MAX) ? cntQ : cntQ + 1'b1;
    end
  end

  // Accept fires on the cycle the count reaches its ceiling; held stays up while saturated.
  assign oAccept = advance && (cntQ == CNT_PRE);
  assign oHeld   = advance && (cntQ == CNT_MAX);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      prevQ <= '0;
      cntQ  <= '0;
    end else begin
      prevQ <= ivSample;
      cntQ  <= cntD;
    end
  end

endmodule

// File: rtl/ac_cpu_strap_filter.sv
// Synchronises and debounces CPU0/CPU1 socket and ID straps; freezes IDs once qualified.
module ac_cpu_strap_filter
  import ac_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 1000,
  parameter int unsigned CNT_W       = 10
) (
  input  logic                   iClk,
  input  logic                   iRst_n,
  input  logic                   iEnable,
  ac_cpu_strap_filter_if.slave   strapIf
);

  localparam logic [ID_W-1:0] ID_RESET =
    packIds(PROC_ID_SPR, PROC_ID_SPR, PKG_ID_NON_MCP, PKG_ID_NON_MCP);

  logic [STRAP_W-1:0] rawBundle;
  logic [STRAP_W-1:0] syncQ [SYNC_STAGES];
  logic [STRAP_W-1:0] syncV;
  logic [SKT_W-1:0]   syncSkt;
  logic [ID_W-1:0]    syncId;

  strapState_e state, stateNext;

  logic [SKT_W-1:0] sktQ, sktD;
  logic [ID_W-1:0]  idQ, idD;
  logic             validQ, validD;
  logic             chgQ, chgD;
  logic             driftQ, driftD;

  logic qClear, lockClear;
  logic qHeld, qAccept;
  logic sktHeld, sktAccept;
  logic idHeld, idAccept;
  logic unusedOk;

  assign rawBundle = {strapIf.ivCPU_SKT_OCC_RAW, strapIf.ivPROC_ID_CPU0_RAW,
                      strapIf.ivPROC_ID_CPU1_RAW, strapIf.ivPKG_ID_CPU0_RAW,
                      strapIf.ivPKG_ID_CPU1_RAW};

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        syncQ[i] <= '0;
      end
    end else begin
      syncQ[0] <= rawBundle;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        syncQ[i] <= syncQ[i-1];
      end
    end
  end

  assign syncV   = syncQ[SYNC_STAGES-1];
  assign syncSkt = syncV[SKT_LSB +: SKT_W];
  assign syncId  = syncV[ID_W-1:0];

  assign qClear    = !iEnable || (state != ST_QUALIFY);
  assign lockClear = !iEnable || (state != ST_LOCKED);

  // Target ~syncV can never equal a stable sample, so qualification only tracks stability.
  ac_strap_debounce #(.WIDTH(STRAP_W), .DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) uQualify (
    .iClk(iClk), .iRst_n(iRst_n), .iClear(qClear),
    .ivTarget(~syncV), .ivSample(syncV), .oHeld(qHeld), .oAccept(qAccept)
  );

  ac_strap_debounce #(.WIDTH(SKT_W), .DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) uSktTrack (
    .iClk(iClk), .iRst_n(iRst_n), .iClear(lockClear),
    .ivTarget(sktQ), .ivSample(syncSkt), .oHeld(sktHeld), .oAccept(sktAccept)
  );

  ac_strap_debounce #(.WIDTH(ID_W), .DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) uIdTrack (
    .iClk(iClk), .iRst_n(iRst_n), .iClear(lockClear),
    .ivTarget(idQ), .ivSample(syncId), .oHeld(idHeld), .oAccept(idAccept)
  );

  assign unusedOk = qAccept & sktHeld & idHeld;

  always_comb begin
    stateNext = state;
    sktD      = sktQ;
    idD       = idQ;
    validD    = validQ;
    chgD      = 1'b0;
    driftD    = driftQ;
    if (!iEnable) begin
      stateNext = ST_DISABLED;
      sktD      = SKT_ABSENT;
      idD       = ID_RESET;
      validD    = 1'b0;
      driftD    = 1'b0;
    end else begin
      case (state)
        ST_DISABLED: begin
          stateNext = ST_QUALIFY;
          sktD      = SKT_ABSENT;
          idD       = ID_RESET;
          validD    = 1'b0;
          driftD    = 1'b0;
        end
        ST_QUALIFY: begin
          if (qHeld) begin
            stateNext = ST_LOCKED;
            sktD      = syncSkt;
            idD       = syncId;
            validD    = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (sktAccept) begin
            sktD = syncSkt;
            chgD = 1'b1;
          end
          if (idAccept) begin
            driftD = 1'b1;
          end
        end
        default: stateNext = ST_DISABLED;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state  <= ST_DISABLED;
      sktQ   <= SKT_ABSENT;
      idQ    <= ID_RESET;
      validQ <= 1'b0;
      chgQ   <= 1'b0;
      driftQ <= 1'b0;
    end else begin
      state  <= stateNext;
      sktQ   <= sktD;
      idQ    <= idD;
      validQ <= validD;
      chgQ   <= chgD;
      driftQ <= driftD;
    end
  end

  assign strapIf.ovCPU_SKT_OCC  = sktQ;
  assign strapIf.ovPROC_ID_CPU0 = idQ[PROC0_LSB +: 2];
  assign strapIf.ovPROC_ID_CPU1 = idQ[PROC1_LSB +: 2];
  assign strapIf.ovPKG_ID_CPU0  = idQ[PKG0_LSB +: 3];
  assign strapIf.ovPKG_ID_CPU1  = idQ[PKG1_LSB +: 3];
  assign strapIf.oSTRAPS_VALID  = validQ;
  assign strapIf.oSKT_CHANGE    = chgQ;
  assign strapIf.oID_DRIFT      = driftQ;

endmodule

// File: tb/tb_ac_cpu_strap_filter.sv
// Directed scoreboard bench for ac_cpu_strap_filter with DEB_CYCLES=8, SYNC_STAGES=2.
module tb_ac_cpu_strap_filter;
  import ac_pkg::*;

  logic iClk   = 1'b0;
  logic iRst_n = 1'b0;
  logic iEnable = 1'b0;

  ac_cpu_strap_filter_if strapIf();

  ac_cpu_strap_filter #(.SYNC_STAGES(2), .DEB_CYCLES(8), .CNT_W(4)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iEnable(iEnable), .strapIf(strapIf)
  );

  always #5 iClk = ~iClk;

  int vecCnt  = 0;
  int missCnt = 0;

  typedef struct {
    string      tag;
    logic [1:0] skt, p0, p1;
    logic [2:0] k0, k1;
    logic       valid, chg, drift;
  } snap_t;

  snap_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCnt++;
    assert (obs === exp) else begin
      missCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expectOut(input string tag, input logic [1:0] skt, input logic [1:0] p0,
                           input logic [1:0] p1, input logic [2:0] k0, input logic [2:0] k1,
                           input logic valid, input logic chg, input logic drift);
    snap_t s;
    s.tag = tag; s.skt = skt; s.p0 = p0; s.p1 = p1; s.k0 = k0; s.k1 = k1;
    s.valid = valid; s.chg = chg; s.drift = drift;
    sbq.push_back(s);
  endtask

  task automatic compareOut();
    snap_t s;
    if (sbq.size() == 0) begin
      vecCnt++;
      missCnt++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    s = sbq.pop_front();
    chk({s.tag, ".skt"},   32'(strapIf.ovCPU_SKT_OCC),  32'(s.skt));
    chk({s.tag, ".proc0"}, 32'(strapIf.ovPROC_ID_CPU0), 32'(s.p0));
    chk({s.tag, ".proc1"}, 32'(strapIf.ovPROC_ID_CPU1), 32'(s.p1));
    chk({s.tag, ".pkg0"},  32'(strapIf.ovPKG_ID_CPU0),  32'(s.k0));
    chk({s.tag, ".pkg1"},  32'(strapIf.ovPKG_ID_CPU1),  32'(s.k1));
    chk({s.tag, ".valid"}, 32'(strapIf.oSTRAPS_VALID),  32'(s.valid));
    chk({s.tag, ".chg"},   32'(strapIf.oSKT_CHANGE),    32'(s.chg));
    chk({s.tag, ".drift"}, 32'(strapIf.oID_DRIFT),      32'(s.drift));
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return strapIf.oSTRAPS_VALID;
      1:       return strapIf.oSKT_CHANGE;
      default: return strapIf.oID_DRIFT;
    endcase
  endfunction

  // Cycles until the selected output goes high; returns maxCyc on timeout.
  task automatic waitFor(input int which, input int maxCyc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sig(which) && n < maxCyc);
  endtask

  task automatic setRaw(input logic [1:0] skt, input logic [1:0] p0, input logic [1:0] p1,
                        input logic [2:0] k0, input logic [2:0] k1);
    strapIf.ivCPU_SKT_OCC_RAW  = skt;
    strapIf.ivPROC_ID_CPU0_RAW = p0;
    strapIf.ivPROC_ID_CPU1_RAW = p1;
    strapIf.ivPKG_ID_CPU0_RAW  = k0;
    strapIf.ivPKG_ID_CPU1_RAW  = k1;
  endtask

  initial begin
    int n;
    int seen;

    setRaw(2'b00, PROC_ID_GNR, PROC_ID_GNR, PKG_ID_HBM, PKG_ID_HBM);
    repeat (3) tick();
    expectOut("reset", 2'b11, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    compareOut();

    // Power-up: raw held from reset, enable on release.
    iRst_n  = 1'b1;
    iEnable = 1'b1;
    waitFor(0, 40, n);
    chk("pwr_latency", n, 11);
    expectOut("pwr_out", 2'b00, 2'b10, 2'b10, 3'b010, 3'b010, 1'b1, 1'b0, 1'b0);
    compareOut();

    // Socket removal on CPU1.
    strapIf.ivCPU_SKT_OCC_RAW = 2'b10;
    waitFor(1, 40, n);
    chk("skt_latency", n, 10);
    expectOut("skt_out", 2'b10, 2'b10, 2'b10, 3'b010, 3'b010, 1'b1, 1'b1, 1'b0);
    compareOut();
    tick();
    chk("skt_pulse_width", 32'(strapIf.oSKT_CHANGE), 0);

    // Six-cycle glitch on CPU0 socket bit.
    seen = 0;
    strapIf.ivCPU_SKT_OCC_RAW = 2'b11;
    repeat (6) begin tick(); if (strapIf.oSKT_CHANGE) seen++; end
    strapIf.ivCPU_SKT_OCC_RAW = 2'b10;
    repeat (20) begin tick(); if (strapIf.oSKT_CHANGE) seen++; end
    chk("glitch_chg_count", seen, 0);
    expectOut("glitch_out", 2'b10, 2'b10, 2'b10, 3'b010, 3'b010, 1'b1, 1'b0, 1'b0);
    compareOut();

    // ID drift on CPU1 processor ID, held 20 cycles then reverted.
    strapIf.ivPROC_ID_CPU1_RAW = PROC_ID_SPR;
    waitFor(2, 40, n);
    chk("drift_latency", n, 10);
    repeat (10) tick();
    expectOut("drift_held", 2'b10, 2'b10, 2'b10, 3'b010, 3'b010, 1'b1, 1'b0, 1'b1);
    compareOut();
    strapIf.ivPROC_ID_CPU1_RAW = PROC_ID_GNR;
    repeat (15) tick();
    expectOut("drift_sticky", 2'b10, 2'b10, 2'b10, 3'b010, 3'b010, 1'b1, 1'b0, 1'b1);
    compareOut();

    // Disable while locked.
    iEnable = 1'b0;
    tick();
    expectOut("dis_locked", 2'b11, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    compareOut();

    // Bounce PKG0 bit1 every 5 cycles for 40 cycles, ending at 3'b000.
    iEnable = 1'b1;
    seen = 0;
    for (int k = 0; k < 9; k++) begin
      strapIf.ivPKG_ID_CPU0_RAW = strapIf.ivPKG_ID_CPU0_RAW ^ 3'b010;
      if (k < 8) begin
        repeat (5) begin tick(); if (strapIf.oSTRAPS_VALID) seen++; end
      end
    end
    chk("bounce_valid_low", seen, 0);
    waitFor(0, 40, n);
    chk("bounce_latency", n, 11);
    expectOut("bounce_out", 2'b10, 2'b10, 2'b10, 3'b000, 3'b010, 1'b1, 1'b0, 1'b0);
    compareOut();

    // Disable during QUALIFY with cntQ at 5 (straps stable, count starts from DISABLED).
    iEnable = 1'b0;
    tick();
    iEnable = 1'b1;
    repeat (6) tick();
    chk("qual_not_valid", 32'(strapIf.oSTRAPS_VALID), 0);
    iEnable = 1'b0;
    tick();
    expectOut("dis_qualify", 2'b11, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    compareOut();

    // Re-enable with a fresh strap edge: full latency from that edge.
    iEnable = 1'b1;
    strapIf.ivCPU_SKT_OCC_RAW = 2'b00;
    waitFor(0, 40, n);
    chk("reen_latency", n, 11);
    expectOut("reen_out", 2'b00, 2'b10, 2'b10, 3'b000, 3'b010, 1'b1, 1'b0, 1'b0);
    compareOut();

    // Asynchronous reset mid-cycle while locked.
    #2;
    iRst_n = 1'b0;
    #1;
    expectOut("async_rst", 2'b11, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    compareOut();
    tick();
    iRst_n = 1'b1;
    waitFor(0, 40, n);
    chk("rst_requal_latency", n, 11);
    expectOut("rst_requal", 2'b00, 2'b10, 2'b10, 3'b000, 3'b010, 1'b1, 1'b0, 1'b0);
    compareOut();

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

endmodule
